// File: rtl/morse_message_sequencer.sv
// Letter FIFO plus timing FSM that feeds queued 3-bit letter codes to morse_encoder.
// Each letter gets one start tick, its 16-tick symbol pattern and an inter-letter gap.
module morse_message_sequencer #(
  parameter int TICK_DIV     = 25_000_000,
  parameter int SYMBOL_TICKS = 16,
  parameter int GAP_TICKS    = 6,
  parameter int DEPTH        = 8,
  parameter int CW           = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [2:0]    wr_letter,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic          go,
  input  logic          abort,
  output logic [2:0]    enc_letter,
  output logic          enc_start,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] count
);

  localparam int DW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAXT = (SYMBOL_TICKS > GAP_TICKS) ? SYMBOL_TICKS : GAP_TICKS;
  localparam int TW   = $clog2(MAXT + 1);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] SEND = 3'd2;
  localparam logic [2:0] GAP  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]    state_reg, state_next;
  logic [DW-1:0] div_reg;
  logic [TW-1:0] tick_cnt_reg;
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [2:0]    enc_letter_reg;
  logic          enc_start_reg;
  logic          done_reg;
  logic [2:0]    mem [DEPTH];

  logic tick;
  logic pop;
  logic push;
  logic state_change;

  assign tick     = (div_reg == DW'(TICK_DIV - 1));
  assign wr_ready = (count_reg != CW'(DEPTH));
  // abort outranks every queue operation, including a write on the same edge
  assign push     = wr_valid && wr_ready && !abort;

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (go && count_reg != '0) begin
          pop        = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (tick) state_next = SEND;
      end
      SEND: begin
        if (tick && tick_cnt_reg == TW'(SYMBOL_TICKS - 1)) state_next = GAP;
      end
      GAP: begin
        if (tick && tick_cnt_reg == TW'(GAP_TICKS - 1)) begin
          if (count_reg != '0) begin
            pop        = 1'b1;
            state_next = LOAD;
          end else begin
            state_next = DONE;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
      pop        = 1'b0;
    end
  end

  assign state_change = (state_next != state_reg);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Timing restarts on every state entry so each state spans whole ticks.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      div_reg       <= '0;
      tick_cnt_reg  <= '0;
      enc_start_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      enc_start_reg <= (state_next == LOAD);
      done_reg      <= (state_next == DONE);
      if (state_change) begin
        div_reg      <= '0;
        tick_cnt_reg <= '0;
      end else if (tick) begin
        div_reg      <= '0;
        tick_cnt_reg <= tick_cnt_reg + TW'(1);
      end else begin
        div_reg <= div_reg + DW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      enc_letter_reg <= 3'b000;
    end else if (abort) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop) begin
        rd_ptr_reg     <= ptr_inc(rd_ptr_reg);
        enc_letter_reg <= mem[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_reg] <= wr_letter;
  end

  assign enc_letter = enc_letter_reg;
  assign enc_start  = enc_start_reg;
  assign busy       = (state_reg != IDLE);
  assign done       = done_reg;
  assign count      = count_reg;

endmodule

// File: tb/tb_morse_message_sequencer.sv
// Randomised self-checking bench for morse_message_sequencer against a queue-based
// timing model (TICK_DIV=4, SYMBOL_TICKS=16, GAP_TICKS=6, DEPTH=4, P=92).
module tb_morse_message_sequencer;

  localparam int TD = 4;
  localparam int ST = 16;
  localparam int GT = 6;
  localparam int DP = 4;
  localparam int CW = 3;
  localparam int P  = (1 + ST + GT) * TD;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    wr_letter = 3'b000;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic          go = 1'b0;
  logic          abort = 1'b0;
  logic [2:0]    enc_letter;
  logic          enc_start;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  morse_message_sequencer #(
    .TICK_DIV(TD), .SYMBOL_TICKS(ST), .GAP_TICKS(GT), .DEPTH(DP)
  ) dut (
    .clock(clock), .reset(reset), .wr_letter(wr_letter), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .go(go), .abort(abort), .enc_letter(enc_letter),
    .enc_start(enc_start), .busy(busy), .done(done), .count(count)
  );

  always #5 clock = ~clock;

  logic [9:0] obs;
  assign obs = {enc_letter, enc_start, busy, done, wr_ready, count};

  // Model: queue of pending letters; m_t counts edges since the current letter was loaded.
  logic [2:0] m_q[$];
  bit         m_run, m_done, m_start;
  logic [2:0] m_letter;
  int         m_t;

  function automatic logic [9:0] exp_vec();
    exp_vec = {m_letter, m_start, m_run | m_done, m_done, m_q.size() < DP, CW'(m_q.size())};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_run = 0; m_done = 0; m_start = 0; m_letter = 3'b000; m_t = 0;
  endtask

  task automatic model_edge(input bit wv, input logic [2:0] wl, input bit g, input bit ab);
    int sz;
    bit do_pop;
    sz = m_q.size();
    do_pop = 0;
    if (ab) begin
      m_q.delete();
      m_run = 0; m_done = 0; m_start = 0;
      return;
    end
    if (m_done) begin
      m_done = 0;
    end else if (!m_run) begin
      if (g && sz > 0) begin
        do_pop = 1; m_run = 1; m_t = 0; m_start = 1;
      end
    end else begin
      m_t++;
      if (m_t == TD) m_start = 0;
      if (m_t == P) begin
        if (sz > 0) begin
          do_pop = 1; m_start = 1; m_t = 0;
        end else begin
          m_run = 0; m_done = 1;
        end
      end
    end
    if (do_pop) m_letter = m_q.pop_front();
    if (wv && sz < DP) m_q.push_back(wl);
  endtask

  // Inputs change on the falling edge; outputs are observed on the falling edge.
  task automatic step(input bit wv, input logic [2:0] wl, input bit g, input bit ab);
    wr_valid = wv; wr_letter = wl; go = g; abort = ab;
    @(posedge clock);
    model_edge(wv, wl, g, ab);
    @(negedge clock);
    wr_valid = 0; go = 0; abort = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    model_reset();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
    n_checks++; if (enc_letter !== 3'b000) begin n_fail++; $display("FAIL reset_enc_letter got=%b exp=000", enc_letter); end
    n_checks++; if (enc_start !== 1'b0) begin n_fail++; $display("FAIL reset_enc_start got=%b exp=0", enc_start); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single();
    int done_e = -1, idle_e = -1;
    step(1, 3'b001, 0, 0);
    step(0, 3'b000, 1, 0);
    n_checks++; if (enc_start !== 1'b1 || enc_letter !== 3'b001 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_start got start=%b letter=%b busy=%b exp 1/001/1", enc_start, enc_letter, busy);
    end
    for (int e = 1; e <= 100; e++) begin
      step(0, 3'b000, 0, 0);
      n_checks++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL single_cycle e=%0d got=%b exp=%b", e, obs, exp_vec()); end
      if (done === 1'b1 && done_e < 0) done_e = e;
      if (busy === 1'b0 && idle_e < 0) idle_e = e;
    end
    n_checks++; if (done_e != P) begin n_fail++; $display("FAIL single_done_edge got=%0d exp=%0d", done_e, P); end
    n_checks++; if (idle_e != P + 1) begin n_fail++; $display("FAIL single_idle_edge got=%0d exp=%0d", idle_e, P + 1); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_count got=%0d exp=0", count); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 5; i++) begin
      step(1, 3'($urandom_range(0, 7)), 0, 0);
      n_checks++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL fill_write i=%0d got=%b exp=%b", i, obs, exp_vec()); end
    end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count got=%0d exp=4", count); end
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL fill_wr_ready got=%b exp=0", wr_ready); end
    step(1, 3'b010, 0, 1);
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL fill_abort_count got=%0d exp=0", count); end
    step(1, 3'b011, 0, 0);
    step(1, 3'b100, 0, 0);
    step(1, 3'b101, 1, 0);
    n_checks++; if (count !== 3'd2 || enc_letter !== 3'b011) begin
      n_fail++; $display("FAIL fill_push_pop got count=%0d letter=%b exp 2/011", count, enc_letter);
    end
    for (int e = 1; e <= 3 * P + 2; e++) begin
      step(0, 3'b000, 0, 0);
      n_checks++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL fill_cycle e=%0d got=%b exp=%b", e, obs, exp_vec()); end
    end
  endtask

  task automatic test_order();
    int rise_e[$];
    logic [2:0] rise_l[$];
    int n_done = 0, done_e = -1;
    logic prev;
    step(1, 3'b000, 0, 0);
    step(1, 3'b110, 0, 0);
    step(1, 3'b111, 0, 0);
    prev = enc_start;
    step(0, 3'b000, 1, 0);
    if (enc_start === 1'b1 && prev !== 1'b1) begin rise_e.push_back(0); rise_l.push_back(enc_letter); end
    prev = enc_start;
    for (int e = 1; e <= 3 * P + 4; e++) begin
      step(0, 3'b000, 0, 0);
      n_checks++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL order_cycle e=%0d got=%b exp=%b", e, obs, exp_vec()); end
      if (enc_start === 1'b1 && prev !== 1'b1) begin rise_e.push_back(e); rise_l.push_back(enc_letter); end
      prev = enc_start;
      if (done === 1'b1) begin n_done++; done_e = e; end
    end
    n_checks++; if (rise_e.size() != 3) begin n_fail++; $display("FAIL order_rises got=%0d exp=3", rise_e.size()); end
    else begin
      n_checks++; if (rise_e[0] != 0 || rise_l[0] !== 3'b000) begin n_fail++; $display("FAIL order_l0 got e=%0d l=%b exp 0/000", rise_e[0], rise_l[0]); end
      n_checks++; if (rise_e[1] != P || rise_l[1] !== 3'b110) begin n_fail++; $display("FAIL order_l1 got e=%0d l=%b exp %0d/110", rise_e[1], rise_l[1], P); end
      n_checks++; if (rise_e[2] != 2 * P || rise_l[2] !== 3'b111) begin n_fail++; $display("FAIL order_l2 got e=%0d l=%b exp %0d/111", rise_e[2], rise_l[2], 2 * P); end
    end
    n_checks++; if (n_done != 1 || done_e != 3 * P) begin n_fail++; $display("FAIL order_done got n=%0d e=%0d exp 1/%0d", n_done, done_e, 3 * P); end
  endtask

  task automatic test_abort();
    int n_done = 0;
    step(1, 3'($urandom_range(0, 7)), 0, 0);
    step(1, 3'($urandom_range(0, 7)), 0, 0);
    step(0, 3'b000, 1, 0);
    for (int e = 1; e < 30; e++) begin
      step(0, 3'b000, 0, 0);
      n_checks++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL abort_pre e=%0d got=%b exp=%b", e, obs, exp_vec()); end
    end
    step(1, 3'b111, 0, 1);
    n_checks++; if (busy !== 1'b0 || count !== 3'd0 || enc_start !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_state got busy=%b count=%0d start=%b done=%b exp 0/0/0/0", busy, count, enc_start, done);
    end
    for (int e = 0; e < 10; e++) begin
      step(0, 3'b000, 0, 0);
      if (done === 1'b1) n_done++;
    end
    n_checks++; if (n_done != 0) begin n_fail++; $display("FAIL abort_no_done got=%0d exp=0", n_done); end
  endtask

  task automatic test_gap_write();
    int done_e = -1, n_done = 0, load2_e = -1;
    logic [2:0] load2_l = 3'b000;
    logic prev;
    step(0, 3'b000, 1, 0);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL empty_go_busy got=%b exp=0", busy); end
    step(1, 3'($urandom_range(0, 7)), 0, 0);
    step(0, 3'b000, 1, 0);
    prev = enc_start;
    for (int e = 1; e <= 2 * P + 4; e++) begin
      step(e == 80, 3'b101, 0, 0);
      n_checks++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL gap_cycle e=%0d got=%b exp=%b", e, obs, exp_vec()); end
      if (enc_start === 1'b1 && prev !== 1'b1 && load2_e < 0) begin load2_e = e; load2_l = enc_letter; end
      prev = enc_start;
      if (done === 1'b1) begin n_done++; done_e = e; end
    end
    n_checks++; if (load2_e != P || load2_l !== 3'b101) begin n_fail++; $display("FAIL gap_load got e=%0d l=%b exp %0d/101", load2_e, load2_l, P); end
    n_checks++; if (n_done != 1 || done_e != 2 * P) begin n_fail++; $display("FAIL gap_done got n=%0d e=%0d exp 1/%0d", n_done, done_e, 2 * P); end
  endtask

  task automatic test_async_reset();
    step(1, 3'b110, 0, 0);
    step(1, 3'b010, 0, 0);
    step(0, 3'b000, 1, 0);
    step(0, 3'b000, 0, 0);
    #2 reset = 1'b0;
    #1;
    n_checks++; if (enc_start !== 1'b0 || busy !== 1'b0 || count !== 3'd0 || enc_letter !== 3'b000) begin
      n_fail++; $display("FAIL async_reset got start=%b busy=%b count=%0d letter=%b exp 0/0/0/000", enc_start, busy, count, enc_letter);
    end
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    step(0, 3'b000, 0, 0);
    n_checks++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL async_after got=%b exp=%b", obs, exp_vec()); end
  endtask

  task automatic test_random();
    bit wv, g, ab;
    for (int e = 0; e < 3000; e++) begin
      wv = ($urandom_range(0, 29) == 0);
      g  = ($urandom_range(0, 19) == 0);
      ab = ($urandom_range(0, 499) == 0);
      step(wv, 3'($urandom_range(0, 7)), g, ab);
      n_checks++; if (obs !== exp_vec()) begin n_fail++; $display("FAIL random_cycle e=%0d got=%b exp=%b", e, obs, exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_order();
    test_abort();
    test_gap_write();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
